mem_bus_ctrl: RTL and testbench

- Sequencing and arbitration controller for the shared 256-bit tristate memory bus. Addresses 0–6 are main memory; address 7 (3'b111) is the result register.
- Two requesters (port 0: matrix execution unit; port 1: load/store sequencer) issue single-word read or write requests.
- The block grants the bus to one requester and drives address/nEnable/ReadWrite with slave-correct timing.
- Slave timing: slaves latch read data on posedge clk, drive the bus while selected, and sample write data on negedge clk. The block captures read data and signals completion to the owner.

---
 rtl/mem_bus_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: two-port arbiter and sequencer for the shared tristate memory bus.
// Define ARB_RR_EN for round-robin arbitration; without it port 0 has fixed priority.
module mem_bus_ctrl #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic [ADDR_W-1:0] address,
  output logic              nEnable,
  output logic              ReadWrite
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LATCH,
    RD_CAPT,
    WR,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]        req_vec;
  logic [1:0]        rw_vec;
  logic [ADDR_W-1:0] addr_vec  [2];
  logic [DATA_W-1:0] wdata_vec [2];

  assign req_vec      = {req1, req0};
  assign rw_vec       = {rw1, rw0};
  assign addr_vec[0]  = addr0;
  assign addr_vec[1]  = addr1;
  assign wdata_vec[0] = wdata0;
  assign wdata_vec[1] = wdata1;

  logic any_req;
  logic grant;
  logic win;

  assign any_req = |req_vec;
  assign grant   = (state_reg == IDLE) && any_req;

`ifdef ARB_RR_EN
  // Pointer holds the last granted port; on a tie the other port wins.
  logic last_gnt_reg;

  assign win = (&req_vec) ? ~last_gnt_reg : req_vec[1];

  always_ff @(posedge clk) begin
    if (Reset) begin
      last_gnt_reg <= 1'b0;
    end else if (grant) begin
      last_gnt_reg <= win;
    end
  end
`else
  assign win = ~req_vec[0];
`endif

  logic              owner_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              nen_reg, nen_next;
  logic              rdwr_reg, rdwr_next;
  logic              drive_reg, drive_next;
  logic              busy_reg, busy_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic [1:0]        done_reg, done_next;

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    state_next = state_reg;
    nen_next   = 1'b1;
    rdwr_next  = 1'b1;
    drive_next = 1'b0;
    busy_next  = 1'b1;
    case (state_reg)
      IDLE:     if (any_req) state_next = rw_vec[win] ? RD_LATCH : WR;
      RD_LATCH: state_next = RD_CAPT;
      RD_CAPT:  state_next = DONE;
      WR:       state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    case (state_next)
      RD_LATCH, RD_CAPT: nen_next = 1'b0;
      WR: begin
        nen_next   = 1'b0;
        rdwr_next  = 1'b0;
        drive_next = 1'b1;
      end
      IDLE:    busy_next = 1'b0;
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign gnt_next[gi]  = grant && (win == 1'(gi));
      assign done_next[gi] = (state_next == DONE) && (owner_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      nen_reg   <= 1'b1;
      rdwr_reg  <= 1'b1;
      drive_reg <= 1'b0;
      busy_reg  <= 1'b0;
      gnt_reg   <= '0;
      done_reg  <= '0;
    end else begin
      state_reg <= state_next;
      nen_reg   <= nen_next;
      rdwr_reg  <= rdwr_next;
      drive_reg <= drive_next;
      busy_reg  <= busy_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      if (grant) begin
        owner_reg <= win;
        addr_reg  <= addr_vec[win];
        wdata_reg <= wdata_vec[win];
      end
      // The slave drives the bus throughout RD_CAPT; capture at its closing edge.
      if (state_reg == RD_CAPT) begin
        rdata_reg <= dataBus;
      end
    end
  end

  assign dataBus   = drive_reg ? wdata_reg : {DATA_W{1'bz}};
  assign address   = addr_reg;
  assign nEnable   = nen_reg;
  assign ReadWrite = rdwr_reg;
  assign busy      = busy_reg;
  assign rdata     = rdata_reg;
  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign done0     = done_reg[0];
  assign done1     = done_reg[1];

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: memory slave model, transaction-level reference
// model, per-cycle compare process, directed cases and randomized two-port traffic.
module tb_mem_bus_ctrl;

  logic         clk;
  logic         Reset;
  logic         req0, rw0, req1, rw1;
  logic [2:0]   addr0, addr1;
  logic [255:0] wdata0, wdata1;
  logic         gnt0, done0, gnt1, done1;
  logic [255:0] rdata;
  logic         busy;
  wire  [255:0] data_bus;
  logic [2:0]   address;
  logic         nEnable, ReadWrite;

  int errors = 0;
  int checks = 0;

  mem_bus_ctrl #(.DATA_W(256), .ADDR_W(3)) dut (
    .clk(clk), .Reset(Reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .busy(busy), .dataBus(data_bus), .address(address),
    .nEnable(nEnable), .ReadWrite(ReadWrite)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory slave on the bus ----------------
  logic [255:0] slave_mem [8];
  logic [255:0] slave_buf;
  logic         slave_valid;
  logic         pre_en;
  logic [2:0]   pre_addr;
  logic [255:0] pre_data;

  assign data_bus = (!nEnable && ReadWrite && slave_valid) ? slave_buf : {256{1'bz}};

  always @(posedge clk) begin
    if (!nEnable && ReadWrite) begin
      slave_buf   <= slave_mem[address];
      slave_valid <= 1'b1;
    end else begin
      slave_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (pre_en) slave_mem[pre_addr] <= pre_data;
    else if (!nEnable && !ReadWrite) slave_mem[address] <= data_bus;
  end

  // ---------------- check helpers ----------------
  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Each granted transaction expands into a list of expected bus cycles.
  typedef struct {
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         nen;
    logic         rdwr;
    logic         busy;
    logic         bus_z;
    logic         upd;
    logic [2:0]   addr;
    logic [255:0] bus;
    logic [255:0] rd;
  } cyc_t;

  cyc_t         plan [$];
  cyc_t         cur;
  logic [255:0] m_mem [8];
  logic [255:0] m_rdata;
  bit           m_live = 0;
`ifdef ARB_RR_EN
  bit           m_ptr;
`endif

  function automatic cyc_t idle_rec();
    cyc_t r;
    r.gnt = 2'b00; r.done = 2'b00; r.nen = 1'b1; r.rdwr = 1'b1; r.busy = 1'b0;
    r.bus_z = 1'b1; r.upd = 1'b0; r.addr = 3'd0; r.bus = '0; r.rd = '0;
    return r;
  endfunction

  initial begin
    bit p;
    cyc_t r;
    logic [2:0] a;
    cur = idle_rec();
    m_rdata = '0;
    forever begin
      @(posedge clk);
      if (pre_en) m_mem[pre_addr] = pre_data;
      if (Reset) begin
        plan.delete();
        cur = idle_rec();
        m_rdata = '0;
        m_live = 1;
`ifdef ARB_RR_EN
        m_ptr = 1'b0;
`endif
      end else begin
        if (!cur.busy && (req0 || req1)) begin
          if (req0 && req1) begin
`ifdef ARB_RR_EN
            p = ~m_ptr;
`else
            p = 1'b0;
`endif
          end else begin
            p = req1;
          end
`ifdef ARB_RR_EN
          m_ptr = p;
`endif
          a = p ? addr1 : addr0;
          r = idle_rec();
          r.busy = 1'b1; r.nen = 1'b0; r.addr = a; r.gnt[p] = 1'b1;
          if (p ? rw1 : rw0) begin
            plan.push_back(r);
            r.gnt = 2'b00; r.bus_z = 1'b0; r.bus = m_mem[a];
            plan.push_back(r);
            r = idle_rec();
            r.busy = 1'b1; r.done[p] = 1'b1; r.upd = 1'b1; r.rd = m_mem[a];
            plan.push_back(r);
          end else begin
            r.rdwr = 1'b0; r.bus_z = 1'b0; r.bus = p ? wdata1 : wdata0;
            m_mem[a] = r.bus;
            plan.push_back(r);
            r = idle_rec();
            r.busy = 1'b1; r.done[p] = 1'b1;
            plan.push_back(r);
          end
        end
        if (plan.size() > 0) cur = plan.pop_front();
        else cur = idle_rec();
        if (cur.upd) m_rdata = cur.rd;
      end
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk_bit("gnt0", gnt0, cur.gnt[0]);
        chk_bit("gnt1", gnt1, cur.gnt[1]);
        chk_bit("done0", done0, cur.done[0]);
        chk_bit("done1", done1, cur.done[1]);
        chk_bit("nEnable", nEnable, cur.nen);
        chk_bit("ReadWrite", ReadWrite, cur.rdwr);
        chk_bit("busy", busy, cur.busy);
        chk_word("rdata", rdata, m_rdata);
        if (!cur.nen) chk_word("address", 256'(address), 256'(cur.addr));
        if (cur.bus_z) chk_bit("bus_released", ($countones(data_bus) == 0), 1'b1);
        else chk_word("bus_value", data_bus, cur.bus);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_port(input bit p, input logic r, input logic w, input logic [2:0] a,
                            input logic [255:0] d);
    if (p) begin req1 = r; rw1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; rw0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic set_req(input bit p, input logic r);
    if (p) req1 = r;
    else   req0 = r;
  endtask

  task automatic preload(input logic [2:0] a, input logic [255:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic wait_done(output int id);
    id = 2;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done0) begin id = 0; break; end
      if (done1) begin id = 1; break; end
    end
  endtask

  task automatic rand_requester(input bit p, input int n);
    bit held;
    bit got;
    int waited;
    held = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (!held) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        drive_port(p, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand256());
      end
      got = 1'b0;
      waited = 0;
      while (!got && waited < 200) begin
        @(negedge clk);
        waited++;
        if ((p ? gnt1 : gnt0) && $urandom_range(0, 1) == 1)
          drive_port(p, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand256());
        if (p ? done1 : done0) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL rand_done_timeout: port %0d waited %0d cycles, expected done within 200", p, waited);
      end
      held = got && (t < n - 1) && ($urandom_range(0, 3) == 0);
      if (!held) set_req(p, 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] a5;
    int first, second, exp_first, ng;
    int g [3];
    a5 = {32{8'hA5}};
    Reset = 1'b1;
    pre_en = 1'b0; pre_addr = 3'd0; pre_data = '0;
    drive_port(1'b0, 1'b0, 1'b1, 3'd0, '0);
    drive_port(1'b1, 1'b0, 1'b1, 3'd0, '0);
    for (int i = 0; i < 8; i++) preload(3'(i), rand256());
    @(negedge clk);
    chk_bit("reset_nEnable", nEnable, 1'b1);
    chk_bit("reset_ReadWrite", ReadWrite, 1'b1);
    chk_word("reset_address", 256'(address), 256'd0);
    chk_word("reset_rdata", rdata, 256'd0);
    Reset = 1'b0;
    @(negedge clk);

    // simultaneous requests: port 0 write, port 1 read
    exp_first = 0;
`ifdef ARB_RR_EN
    exp_first = 1;
`endif
    drive_port(1'b0, 1'b1, 1'b0, 3'd2, rand256());
    drive_port(1'b1, 1'b1, 1'b1, 3'd6, '0);
    wait_done(first);
    chk_int("tie_first_owner", first, exp_first);
    set_req(1'(exp_first), 1'b0);
    wait_done(second);
    chk_int("tie_second_owner", second, 1 - exp_first);
    set_req(1'b0, 1'b0);
    set_req(1'b1, 1'b0);
    @(negedge clk);

    // single write, with fields changed right after the grant
    drive_port(1'b0, 1'b1, 1'b0, 3'd3, a5);
    @(negedge clk);
    chk_bit("wr_gnt0", gnt0, 1'b1);
    chk_bit("wr_nEnable", nEnable, 1'b0);
    chk_bit("wr_ReadWrite", ReadWrite, 1'b0);
    chk_word("wr_address", 256'(address), 256'd3);
    chk_word("wr_bus", data_bus, a5);
    drive_port(1'b0, 1'b1, 1'b1, 3'd5, '0);
    @(negedge clk);
    chk_bit("wr_done0", done0, 1'b1);
    set_req(1'b0, 1'b0);
    @(negedge clk);
    chk_word("wr_landed", slave_mem[3], a5);

    // read of the result register from port 1
    preload(3'd7, 256'h1234);
    @(negedge clk);
    drive_port(1'b1, 1'b1, 1'b1, 3'd7, '0);
    @(negedge clk);
    chk_bit("rd_gnt1", gnt1, 1'b1);
    chk_word("rd_address", 256'(address), 256'd7);
    @(negedge clk);
    chk_bit("rd_capt_done1", done1, 1'b0);
    @(negedge clk);
    chk_bit("rd_done1", done1, 1'b1);
    chk_word("rd_rdata", rdata, 256'h1234);
    set_req(1'b1, 1'b0);
    @(negedge clk);

    // back-to-back reads with req0 held high
    g = '{-100, -100, -100};
    ng = 0;
    drive_port(1'b0, 1'b1, 1'b1, 3'd1, '0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt0 && ng < 3) begin g[ng] = i; ng++; end
      if (ng == 3 && done0) break;
    end
    set_req(1'b0, 1'b0);
    chk_int("b2b_grants", ng, 3);
    chk_int("b2b_gap1", g[1] - g[0], 4);
    chk_int("b2b_gap2", g[2] - g[1], 4);
    @(negedge clk);

    // reset asserted for two cycles while in RD_CAPT
    drive_port(1'b0, 1'b1, 1'b1, 3'd4, '0);
    @(negedge clk);
    @(negedge clk);
    chk_bit("rst_in_capt_nEnable", nEnable, 1'b0);
    Reset = 1'b1;
    set_req(1'b0, 1'b0);
    @(negedge clk);
    chk_bit("rst_abort_nEnable", nEnable, 1'b1);
    chk_bit("rst_abort_busy", busy, 1'b0);
    chk_bit("rst_abort_done0", done0, 1'b0);
    chk_word("rst_abort_rdata", rdata, 256'd0);
    chk_bit("rst_abort_bus_released", ($countones(data_bus) == 0), 1'b1);
    @(negedge clk);
    chk_bit("rst_hold_done0", done0, 1'b0);
    Reset = 1'b0;
    @(negedge clk);

    // randomized traffic from both requesters
    fork
      rand_requester(1'b0, 25);
      rand_requester(1'b1, 25);
    join
    set_req(1'b0, 1'b0);
    set_req(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) chk_word("final_mem", slave_mem[i], m_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 30000 cycles, expected completion earlier");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
